// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for the wide adder sequencer.
interface wide_add_sequencer_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  // Producer/consumer side: supplies operands and accepts results.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-word adder: one 16-bit Kogge-Stone slice per clock, LS slice first,
// carry chained through a register, results held until consumed.

// 16-bit parallel-prefix (Kogge-Stone) adder.
module KoggeStone16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  localparam int unsigned LEVELS = 4;

  // Level k holds group generate/propagate spanning 2^k bits ending at bit i.
  logic [LEVELS:0][15:0] g;
  logic [LEVELS:0][15:0] p;
  logic [16:0]           c;

  assign g[0] = A & B;
  assign p[0] = A ^ B;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int D = 1 << (k - 1);
    for (genvar i = 0; i < 16; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign g[k][i] = g[k-1][i] | (p[k-1][i] & g[k-1][i-D]);
        assign p[k][i] = p[k-1][i] & p[k-1][i-D];
      end else begin : g_pass
        assign g[k][i] = g[k-1][i];
        assign p[k][i] = p[k-1][i];
      end
    end
  end

  // Carry into bit i+1 folds the incoming carry through the full prefix group.
  assign c[0] = Cin;
  for (genvar i = 0; i < 16; i++) begin : g_carry
    assign c[i+1] = g[LEVELS][i] | (p[LEVELS][i] & Cin);
  end

  assign S    = p[0] ^ c[15:0];
  assign Cout = c[16];
endmodule

module wide_add_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_add_sequencer_if.slave  bus
);
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [WORDS-1:0][15:0]  a_q;
  logic [WORDS-1:0][15:0]  b_q;
  logic [WORDS-1:0][15:0]  sum_q;
  logic                    c_q;
  logic                    cout_q;
  logic                    in_ready_q;
  logic                    out_valid_q;

  logic [15:0]             add_s;
  logic                    add_cout;

  // Single shared slice adder; operands come from the registered copies only.
  KoggeStone16bit u_ks (
    .A    (a_q[idx]),
    .B    (b_q[idx]),
    .Cin  (c_q),
    .S    (add_s),
    .Cout (add_cout)
  );

  // Sequencer FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            c_q        <= bus.cin;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= ADD;
          end
        end
        ADD: begin
          sum_q[idx] <= add_s;
          c_q        <= add_cout;
          if (idx == IW'(WORDS - 1)) begin
            cout_q      <= add_cout;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          // Release takes priority; a pending operand waits one more edge.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Sequential multi-word adder front end for the 16-bit Kogge-Stone adder (`KoggeStone16bit`). It accepts a wide operand pair and a carry-in over a valid/ready handshake. It feeds the operands to a single internal `KoggeStone16bit` instance one 16-bit slice per clock, least-significant slice first, chaining the carry through a register. It then presents the full-width sum and carry-out over a second valid/ready handshake.

## Interface
Parameters:
- WORDS, default 4: number of 16-bit slices; operand width W = 16*WORDS; legal range WORDS >= 1.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into slice 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  (a + b + cin) mod 2^W.
- cout  output  1  carry out of bit W-1.

## Operation
- Exactly one `KoggeStone16bit` instance. Its A/B are the registered slices a_q[16*idx +: 16] and b_q[16*idx +: 16]. Its Cin is the carry register c_q.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: register a -> a_q, b -> b_q, cin -> c_q; set idx = 0; go to ADD.
- ADD (each clock):
  - sum_q[16*idx +: 16] <= adder S.
  - c_q <= adder Cout.
  - If idx == WORDS-1: cout_q <= adder Cout and go to DONE; otherwise idx <= idx+1.
- DONE:
  - out_valid = 1; sum = sum_q and cout = cout_q, held stable.
  - On out_ready: go to IDLE.
- in_ready = 0 in ADD and DONE. in_valid and the a/b/cin inputs are ignored outside IDLE.
- sum and cout are driven from registers at all times. Their value outside DONE is unspecified but must not glitch from combinational adder paths.
- Arithmetic:
  - Unsigned, wraps mod 2^W; cout carries the overflow.
  - Signed overflow is not reported.
- idx counter width: clog2(WORDS), minimum 1 bit.
- When WORDS = 1, ADD lasts exactly one cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, idx = 0.
  - a_q, b_q, c_q, sum_q, cout_q = 0.
  - Outputs: out_valid = 0, in_ready = 1, sum = 0, cout = 0.
- Reset asserted mid-ADD or mid-DONE: the operation is discarded immediately and no out_valid pulse occurs. After deassertion the block is in IDLE.
- Latency: the accept edge is edge 0. ADD occupies edges 1..WORDS. out_valid is high after edge WORDS (WORDS clocks from accept).
- Output handshake completes on the first edge with out_valid & out_ready; in_ready rises after that edge.
- Minimum issue period with out_ready held high: WORDS+2 clocks (accept, WORDS adds, release, next accept).
- Backpressure: DONE is held indefinitely while out_ready = 0, with sum/cout/out_valid unchanged.
- Simultaneous in_valid and out_ready in DONE: the result is released and the new operand is not accepted on that edge; it can be accepted on the next edge.
- Critical path: one `KoggeStone16bit` plus slice mux. There is no ripple between slices within a cycle.

## Test plan
All scenarios use WORDS = 4 (W = 64).
- Reset: with rst_n low, expect out_valid=0, in_ready=1, sum=0, cout=0. Release rst_n; no output activity without in_valid.
- Slice carry chain: a=0x0000_0000_0000_FFFF, b=0x1, cin=0.
  - Expect sum=0x0000_0000_0001_0000, cout=0.
  - out_valid must rise exactly 4 clocks after the accept edge.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1.
  - Expect sum=0, cout=1.
  - Also a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000, cin=0 -> sum=0, cout=1.
- Backpressure: complete an add (a=45, b=45), then hold out_ready=0 for 5 clocks while driving in_valid=1 with a different a.
  - sum stays 90, in_ready stays 0, out_valid stays 1.
  - Raise out_ready: the handshake completes and the next operand is accepted one clock later.
- Reset mid-operation: accept a=879, b=5864, then pull rst_n low after the 2nd ADD edge.
  - out_valid is never asserted and outputs return to reset values.
  - Next op a=354, b=6853, cin=1 -> sum=7208, cout=0.
- Random regression: ≥1000 random 64-bit a, b, cin, back-to-back with out_ready=1. Compare against a+b+cin (65-bit), with issue period exactly 6 clocks.
  - Repeat with random out_ready stalls.
